// File: rtl/gol_sim_scheduler.sv
// Game of Life engine sequencer: boot fill, then frame-aligned fill / update / copy
// dispatch on vsync rising edges, with request latching, generation count and done timeouts.
module gol_sim_scheduler #(
  parameter int GEN_W   = 16,
  parameter int TIMEOUT = 65535,
  parameter int TMO_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             vsync,
  input  logic             run,
  input  logic             step,
  input  logic             randomize,
  input  logic             clear,
  input  logic [3:0]       frame_div,
  output logic             init_start,
  output logic             init_fill,
  input  logic             init_done,
  output logic             update_start,
  input  logic             update_done,
  output logic             copy_start,
  input  logic             copy_done,
  output logic             busy,
  output logic [GEN_W-1:0] generation,
  output logic             error
);

  localparam int REQ_STEP  = 0;
  localparam int REQ_RAND  = 1;
  localparam int REQ_CLEAR = 2;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_IDLE,
    ST_INIT,
    ST_UPDATE,
    ST_COPY
  } state_t;

  state_t           state_reg, state_next;
  logic             vsync_q_reg;
  logic             vsync_rise;
  logic [2:0]       req;
  logic [2:0]       req_q_reg;
  logic [2:0]       req_rise;
  logic [2:0]       pend_reg, pend_next;
  logic [2:0]       svc;
  logic [3:0]       frame_cnt_reg, frame_cnt_next;
  logic [TMO_W-1:0] tmo_reg, tmo_next;
  logic [TMO_W-1:0] tmo_inc;
  logic             tmo_hit;
  logic             init_start_reg, init_start_next;
  logic             init_fill_reg, init_fill_next;
  logic             update_start_reg, update_start_next;
  logic             copy_start_reg, copy_start_next;
  logic [GEN_W-1:0] gen_reg, gen_next;
  logic             error_reg, error_next;

  assign req        = {clear, randomize, step};
  assign vsync_rise = vsync & ~vsync_q_reg;
  assign tmo_inc    = tmo_reg + 1'b1;
  assign tmo_hit    = (tmo_inc == TMO_W'(TIMEOUT));

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi = gi + 1) begin : g_req
      assign req_rise[gi] = req[gi] & ~req_q_reg[gi];
      // A fresh edge wins over a same-cycle service so the new request is kept.
      assign pend_next[gi] = req_rise[gi] | (pend_reg[gi] & ~svc[gi]);
    end
  endgenerate

  always_comb begin
    state_next        = state_reg;
    init_start_next   = 1'b0;
    update_start_next = 1'b0;
    copy_start_next   = 1'b0;
    init_fill_next    = init_fill_reg;
    frame_cnt_next    = frame_cnt_reg;
    tmo_next          = tmo_reg;
    gen_next          = gen_reg;
    error_next        = error_reg;
    svc               = '0;

    case (state_reg)
      ST_BOOT: begin
        state_next      = ST_INIT;
        init_start_next = 1'b1;
        init_fill_next  = 1'b1;
        tmo_next        = '0;
      end

      ST_IDLE: begin
        if (vsync_rise) begin
          // Single-step has no meaning while free-running, so drop it.
          if (run) begin
            svc[REQ_STEP] = 1'b1;
          end
          if (pend_reg[REQ_CLEAR]) begin
            svc[REQ_CLEAR]  = 1'b1;
            state_next      = ST_INIT;
            init_start_next = 1'b1;
            init_fill_next  = 1'b0;
            tmo_next        = '0;
          end else if (pend_reg[REQ_RAND]) begin
            svc[REQ_RAND]   = 1'b1;
            state_next      = ST_INIT;
            init_start_next = 1'b1;
            init_fill_next  = 1'b1;
            tmo_next        = '0;
          end else if (run) begin
            if (frame_cnt_reg == frame_div) begin
              state_next        = ST_UPDATE;
              update_start_next = 1'b1;
              frame_cnt_next    = '0;
              tmo_next          = '0;
            end else begin
              frame_cnt_next = frame_cnt_reg + 4'd1;
            end
          end else if (pend_reg[REQ_STEP]) begin
            svc[REQ_STEP]     = 1'b1;
            state_next        = ST_UPDATE;
            update_start_next = 1'b1;
            tmo_next          = '0;
          end
        end
      end

      ST_INIT: begin
        if (init_done) begin
          state_next = ST_IDLE;
          gen_next   = '0;
        end else begin
          tmo_next = tmo_inc;
          if (tmo_hit) begin
            error_next = 1'b1;
            state_next = ST_IDLE;
          end
        end
      end

      ST_UPDATE: begin
        if (update_done) begin
          state_next      = ST_COPY;
          copy_start_next = 1'b1;
          tmo_next        = '0;
        end else begin
          tmo_next = tmo_inc;
          if (tmo_hit) begin
            error_next = 1'b1;
            state_next = ST_IDLE;
          end
        end
      end

      ST_COPY: begin
        if (copy_done) begin
          state_next = ST_IDLE;
          gen_next   = gen_reg + 1'b1;
        end else begin
          tmo_next = tmo_inc;
          if (tmo_hit) begin
            error_next = 1'b1;
            state_next = ST_IDLE;
          end
        end
      end

      default: begin
        state_next = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= ST_BOOT;
      vsync_q_reg      <= 1'b0;
      req_q_reg        <= '0;
      pend_reg         <= '0;
      frame_cnt_reg    <= '0;
      tmo_reg          <= '0;
      init_start_reg   <= 1'b0;
      init_fill_reg    <= 1'b1;
      update_start_reg <= 1'b0;
      copy_start_reg   <= 1'b0;
      gen_reg          <= '0;
      error_reg        <= 1'b0;
    end else begin
      state_reg        <= state_next;
      vsync_q_reg      <= vsync;
      req_q_reg        <= req;
      pend_reg         <= pend_next;
      frame_cnt_reg    <= frame_cnt_next;
      tmo_reg          <= tmo_next;
      init_start_reg   <= init_start_next;
      init_fill_reg    <= init_fill_next;
      update_start_reg <= update_start_next;
      copy_start_reg   <= copy_start_next;
      gen_reg          <= gen_next;
      error_reg        <= error_next;
    end
  end

  assign init_start   = init_start_reg;
  assign init_fill    = init_fill_reg;
  assign update_start = update_start_reg;
  assign copy_start   = copy_start_reg;
  assign busy         = (state_reg != ST_IDLE);
  assign generation   = gen_reg;
  assign error        = error_reg;

endmodule

// File: doc/gol_sim_scheduler.md
Name: gol_sim_scheduler

Overview:
- Sequences the Game of Life simulation engine: boot/randomize/clear fill, then generation update followed by copy-back.
- Triggers work on VGA vsync rising edges, so board rewrites are frame-aligned.
- Handles run/pause, single-step, randomize and clear requests, and counts generations.
- Sits between the top-level ui_in controls and the init/update/copy engine sub-blocks, replacing ad-hoc action muxing.

Parameters:
- GEN_W, 16, width of the generation counter.
- TIMEOUT, 65535, maximum cycles to wait for any done pulse before flagging an error.
- TMO_W, 16, width of the timeout counter; must hold TIMEOUT.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- vsync  in  1  vsync level from hvsync generator; active high.
- run  in  1  1 = free-running simulation, 0 = paused.
- step  in  1  single-step request; rising edge latched.
- randomize  in  1  random refill request; rising edge latched.
- clear  in  1  all-dead refill request; rising edge latched.
- frame_div  in  4  update every frame_div+1 frames while running.
- init_start  out  1  one-cycle pulse; starts board fill.
- init_fill  out  1  fill source, valid with init_start and held until init_done: 1 = LFSR, 0 = zero.
- init_done  in  1  one-cycle pulse from the fill engine.
- update_start  out  1  one-cycle pulse; starts next-state computation.
- update_done  in  1  one-cycle pulse from the update engine.
- copy_start  out  1  one-cycle pulse; starts next-to-current copy.
- copy_done  in  1  one-cycle pulse from the copy engine.
- busy  out  1  high in any state except IDLE.
- generation  out  GEN_W  completed generations since the last fill.
- error  out  1  sticky; set on a done-pulse timeout.

Behaviour:
- Reset values:
  - state = BOOT.
  - all start pulses 0; init_fill = 1; busy = 1; generation = 0; error = 0.
  - frame counter 0; edge registers 0; pending flags 0; timeout counter 0.
- Edge detection: vsync_rise = vsync & ~vsync_q. step, randomize and clear each have their own registered rising-edge detector.
- Pending flags:
  - A detected edge of step, randomize or clear sets a pending flag in any state.
  - A flag clears only when its request is serviced.
- States:
  - BOOT: the next cycle goes to INIT with init_start = 1 and init_fill = 1. Every reset therefore produces a random board.
  - IDLE: on vsync_rise, apply in priority order:
    1. clear pending: go to INIT, init_fill = 0, clear the flag.
    2. else randomize pending: go to INIT, init_fill = 1, clear the flag.
    3. else run = 1 and frame counter == frame_div: go to UPDATE, frame counter = 0.
    4. else run = 1: frame counter += 1.
    5. else run = 0 and step pending: go to UPDATE, clear step.
    - While run = 1, a step pending flag is cleared at every vsync_rise and ignored.
    - While run = 0, the frame counter holds its value.
  - INIT: wait for init_done; then go to IDLE with generation = 0.
  - UPDATE: wait for update_done; then go to COPY with copy_start = 1.
  - COPY: wait for copy_done; then go to IDLE with generation += 1, wrapping modulo 2^GEN_W.
- Latency:
  - A vsync_rise sampled at edge N puts the new state and its start pulse in cycle N+1.
  - A done pulse sampled at edge M puts the next start pulse, or the return to IDLE, in cycle M+1.
  - Each start pulse is exactly one cycle; the engine must not be restarted until its done.
- Done pulses are honoured only in the matching wait state. A done pulse in any other state is ignored and has no side effect.
- Timeout:
  - The timeout counter clears on entry to INIT, UPDATE or COPY and counts each cycle without the awaited done.
  - When the counter reaches TIMEOUT: set error, go to IDLE, leave generation unchanged.
  - error clears only on reset.
- A vsync_rise seen outside IDLE is dropped. It does not advance the frame counter and is not queued.
- A request arriving in the same cycle as the vsync_rise that services it is latched but not serviced until the next vsync_rise.
- A reset asserted mid-operation overrides everything in that cycle. Outputs take their reset values at the next edge, and the boot random fill is re-issued.

Test Plan:
- Boot: release reset with init_done 10 cycles later -> init_start pulses exactly once with init_fill = 1; generation = 0; state IDLE with busy = 0 the cycle after init_done.
- Run, frame_div = 2, engines ack after 5 cycles -> update_start on every 3rd vsync_rise at N+1; copy_start the cycle after update_done; generation 0→1→2 after 3 frames each.
- Paused, run = 0: three step edges before one vsync -> exactly one update/copy cycle, generation += 1; nothing at later vsyncs.
- Clear and randomize both pending at a vsync -> INIT with init_fill = 0 first; the randomize fill (init_fill = 1) follows at the next vsync; generation = 0 after each.
- No copy_done with TIMEOUT = 20 -> error = 1 twenty cycles after copy_start, state IDLE, generation unchanged; a later copy_done pulse is ignored.
- Reset asserted while in UPDATE -> next cycle busy = 1, error = 0, generation = 0; then a new init_start with init_fill = 1.
